mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; legal values are 4 to 64.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; it SHALL be accepted only in IDLE.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
REQ-006 a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 hi  output  WIDTH  product high half, or division remainder.
REQ-011 lo  output  WIDTH  product low half, or division quotient.
REQ-012 div_zero  output  1  divide-by-zero flag.

Function
REQ-013 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-014 In IDLE with start=1 (edge E0), the unit SHALL capture op, the operand magnitudes and the result signs, load the iteration counter with WIDTH, and enter CALC.
REQ-015 In IDLE with start=1, op[1]=1 and b=0, the unit SHALL instead enter DONE directly, set div_zero=1, and leave hi/lo unchanged.
REQ-016 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle on magnitudes, and decrement the counter each cycle.
REQ-017 After exactly WIDTH CALC cycles the FSM SHALL enter FIX.
REQ-018 FIX SHALL apply the sign correction, write hi/lo, and enter DONE; hi/lo SHALL update only in FIX.
REQ-019 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-020 Latency (normal case): hi/lo update at edge E0+WIDTH+1; done is high in the cycle following that edge; busy is high for WIDTH+2 cycles.
REQ-021 Latency (divide-by-zero): done and busy are high only in the cycle following E0.
REQ-022 MULT/MULTU SHALL produce the full 2*WIDTH-bit product as {hi,lo}, with signed or unsigned interpretation per op.
REQ-023 DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 DIV with the most-negative dividend and divisor -1 SHALL give lo = most-negative value and hi = 0, with no flag raised.
REQ-025 DIVU SHALL treat both operands as unsigned.
REQ-026 start SHALL be ignored while busy; op, a and b changes during busy SHALL not affect the result.
REQ-027 div_zero SHALL hold its value until the next accepted start, which clears it unless that operation is again a zero divide.
REQ-028 hi and lo SHALL hold their values indefinitely between operations.
REQ-029 start asserted in the DONE cycle SHALL be ignored; a new operation needs start while in IDLE.

Reset
REQ-030 On reset=1 at a clock edge: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, counter = 0.
REQ-031 Reset SHALL take priority over start and over every state, including mid-CALC and FIX; any operation in progress is abandoned and no done pulse is issued.

Verification (WIDTH=32)
REQ-032 MULT: a=0xFFFFFFFD, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high exactly in the cycle after edge E0+33; busy high for 34 cycles.
REQ-033 DIV: a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001. DIVU: a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1.
REQ-034 DIV: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. MULTU: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 Divide-by-zero: with hi/lo preloaded by a prior MULT, DIV with b=0 -> done one cycle after E0, div_zero=1, hi/lo unchanged; the next valid start clears div_zero.
REQ-036 Robustness: start pulsed and operands changed during CALC -> result unaffected and only one done pulse.
REQ-037 Reset mid-operation: reset at CALC cycle 10 -> all outputs 0 next cycle and no done pulse; a new MULT 6*7 afterwards -> lo=42, hi=0.
REQ-038 Repeat REQ-032 and REQ-035 with WIDTH=8 to cover the parametrised width, e.g. MULT 0xFD*5 -> {hi,lo}=0xFFF1 with done after edge E0+9.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, followed by a single sign-correction cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div, neg_lo, neg_hi;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic             is_signed, sign_a, sign_b, zero_div;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = ~op[0];
  assign sign_a    = is_signed & a[WIDTH-1];
  assign sign_b    = is_signed & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;
  assign zero_div  = op[1] && (b == '0);

  // Multiply: {acc_hi,acc_lo} is the partial product with the multiplier
  // shifting out of acc_lo. Divide: acc_hi is the remainder, acc_lo the
  // dividend shifting out while quotient bits shift in.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  // Remainder stays below the divisor, so a WIDTH-bit difference is exact.
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign q_fix     = neg_lo ? -acc_lo : acc_lo;
  assign r_fix     = neg_hi ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_zero <= zero_div;
          if (!zero_div) begin
            is_div <= op[1];
            neg_lo <= sign_a ^ sign_b;
            neg_hi <= sign_a;
            opnd   <= op[1] ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= op[1] ? mag_a : mag_b;
            cnt    <= CW'(WIDTH);
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) {hi, lo} <= {r_fix, q_fix};
          else        {hi, lo} <= prod_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit at WIDTH=32 and WIDTH=8: spec vectors, corner
// sequences and random ops against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sel8 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  logic [31:0] th[2], tl[2];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start & ~sel8), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32));

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start & sel8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

  always_comb begin
    m_busy = sel8 ? busy8 : busy32;
    m_done = sel8 ? done8 : done32;
    m_dz   = sel8 ? dz8   : dz32;
    m_hi   = sel8 ? {24'b0, hi8} : hi32;
    m_lo   = sel8 ? {24'b0, lo8} : lo32;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on 64-bit integers; returns {dz,hi,lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] aa,
                                        input logic [31:0] bb, input int w,
                                        input logic [31:0] ph, input logic [31:0] pl);
    longint mask, x, y, p;
    mask = (longint'(1) << w) - 1;
    x = longint'(aa) & mask;
    y = longint'(bb) & mask;
    if (!o[0] && x[w-1]) x = x - (longint'(1) << w);
    if (!o[0] && y[w-1]) y = y - (longint'(1) << w);
    if (o[1] && y == 0) return {1'b1, ph, pl};
    if (!o[1]) begin
      p = x * y;
      return {1'b0, 32'((p >> w) & mask), 32'(p & mask)};
    end
    return {1'b0, 32'((x % y) & mask), 32'((x / y) & mask)};
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input bit scramble, input bit poke_done);
    int w, lat, bcnt, exp_lat, idx;
    logic z;
    idx = sel8 ? 1 : 0;
    w = sel8 ? 8 : 32;
    z = o[1] && ((sel8 ? {24'b0, bb[7:0]} : bb) == 32'd0);
    exp_lat = z ? 1 : w + 2;
    @(negedge clk); op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1; bcnt = 0;
    while (!m_done && lat < 100) begin
      if (m_busy) bcnt++;
      if (!z && lat == w + 1)
        chk({nm, " hold before fix"}, {m_hi, m_lo}, {th[idx], tl[idx]});
      if (scramble) begin
        op = 2'($urandom); a = $urandom; b = $urandom; start = 1'($urandom);
      end
      @(negedge clk); lat++;
    end
    if (m_busy) bcnt++;
    start = poke_done;
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
    chk({nm, " hi"}, 64'(m_hi), 64'(eh));
    chk({nm, " lo"}, 64'(m_lo), 64'(el));
    chk({nm, " div_zero"}, 64'(m_dz), 64'(edz));
    @(negedge clk); start = 1'b0;
    chk({nm, " single done"}, {62'b0, m_done, m_busy}, 64'd0);
    th[idx] = eh; tl[idx] = el;
  endtask

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t        vt[10];
  logic [64:0] r;
  int          dn;

  initial begin
    vt[0] = '{1'b0, 2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[1] = '{1'b0, 2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[2] = '{1'b0, 2'b11, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 1'b0};
    vt[3] = '{1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[4] = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[5] = '{1'b0, 2'b00, 32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0};
    vt[6] = '{1'b0, 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[7] = '{1'b1, 2'b00, 32'hFD,       32'd5,        32'hFF,       32'hF1,       1'b0};
    vt[8] = '{1'b1, 2'b10, 32'h80,       32'hFF,       32'h00,       32'h80,       1'b0};
    vt[9] = '{1'b1, 2'b11, 32'hFF,       32'd2,        32'h01,       32'h7F,       1'b0};
    th = '{32'd0, 32'd0}; tl = '{32'd0, 32'd0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset w32", {busy32, done32, dz32, hi32, lo32}, 64'd0);
    chk("reset w8", {busy8, done8, dz8, hi8, lo8}, 64'd0);

    foreach (vt[i]) begin
      sel8 = vt[i].w8;
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
             vt[i].dz, 1'b0, 1'b0);
    end

    // Divide by zero keeps the previous product and flags until next start.
    sel8 = 1'b0;
    run_op("w32 preload", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
    run_op("w32 div0", 2'b10, 32'd123, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("w32 div0 flag hold", 64'(dz32), 64'd1);
    run_op("w32 after div0", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);
    sel8 = 1'b1;
    run_op("w8 preload", 2'b00, 32'hFD, 32'd5, 32'hFF, 32'hF1, 1'b0, 1'b0, 1'b0);
    run_op("w8 div0", 2'b11, 32'h12, 32'h00, 32'hFF, 32'hF1, 1'b1, 1'b0, 1'b0);
    run_op("w8 after div0", 2'b11, 32'h10, 32'd3, 32'h01, 32'h05, 1'b0, 1'b0, 1'b0);

    // Inputs churn and start toggles during the op, start held in DONE.
    sel8 = 1'b0;
    run_op("scramble", 2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 1'b1, 1'b1);

    // Reset at CALC cycle 10 abandons the op without a done pulse.
    @(negedge clk); op = 2'b00; a = 32'h12345; b = 32'h777; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid reset outputs", {busy32, done32, dz32, hi32, lo32}, 64'd0);
    dn = 0;
    repeat (40) begin @(negedge clk); if (done32) dn++; end
    chk("mid reset no done", 64'(dn), 64'd0);
    th = '{32'd0, 32'd0}; tl = '{32'd0, 32'd0};
    run_op("mult after reset", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      sel8 = 1'($urandom);
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = sel8 ? 32'h80 : 32'h80000000;
      r = model(ro, ra, rb, sel8 ? 8 : 32, th[sel8 ? 1 : 0], tl[sel8 ? 1 : 0]);
      run_op($sformatf("rand%0d op%0d w%0d a=%0h b=%0h", i, ro, sel8 ? 8 : 32, ra, rb),
             ro, ra, rb, r[63:32], r[31:0], r[64], 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
